apb_timer_mc: RTL

APB_TIMER_MC -- requirements
Module: apb_timer_mc

---
 rtl/apb_timer_mc.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer: N_CH prescaled up-counters with compare/overflow flags and level IRQs.
// Define APB_TIMER_ONESHOT_EN to implement CTRL.ONESHOT; otherwise CTRL[2] is hardwired to 0.
module apb_timer_mc #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_CH           = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [N_CH-1:0]           irq_o
);

  typedef enum logic [1:0] {
    REG_COUNT  = 2'd0,
    REG_CTRL   = 2'd1,
    REG_CMP    = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  typedef struct packed {
    logic       cmp_ie;
    logic       ovf_ie;
    logic [3:0] presc;
    logic       oneshot;
    logic       autorst;
    logic       en;
  } ctrl_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic       access, wr_en, rd_en, ch_valid;
  logic [3:0] ch_idx;
  reg_e       reg_sel;
  logic       unused_bits;

  logic [32*N_CH-1:0] rd_count_flat, rd_ctrl_flat, rd_cmp_flat, rd_status_flat;

  assign access      = PSEL & PENABLE;
  assign ch_idx      = PADDR[7:4];
  assign reg_sel     = reg_e'(PADDR[3:2]);
  assign ch_valid    = (5'(ch_idx) < 5'(N_CH));
  assign wr_en       = access & PWRITE & ch_valid;
  assign rd_en       = access & ~PWRITE & ch_valid;
  assign PREADY      = 1'b1;
  assign PSLVERR     = access & ~ch_valid;
  assign unused_bits = ^{PADDR, PWDATA};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ctrl_t                ctrl_q, ctrl_d;
    logic [CNT_WIDTH-1:0] count_q, count_d, cmp_q, cmp_d;
    logic [1:0]           status_q, status_d;   // {CMP, OVF}
    logic [3:0]           pcnt_q, pcnt_d;
    logic                 wr_hit, tick, cmp_hit, ovf_hit;

    assign wr_hit  = wr_en && (ch_idx == 4'(g));
    assign tick    = ctrl_q.en && (pcnt_q == ctrl_q.presc);
    assign cmp_hit = tick && (count_q == cmp_q);
    assign ovf_hit = tick && (count_q == CNT_MAX);

    always_comb begin
      // NOTE: every _d starts from its hold value so no branch leaves it unassigned (no latch).
      ctrl_d   = ctrl_q;
      count_d  = count_q;
      cmp_d    = cmp_q;
      pcnt_d   = pcnt_q;
      status_d = status_q | {cmp_hit, ovf_hit};

      if (ctrl_q.en) pcnt_d = tick ? 4'd0 : pcnt_q + 4'd1;
      // Overflow wraps through the natural +1; AUTORST only matters on a compare match.
      if (tick) count_d = (cmp_hit && ctrl_q.autorst) ? '0 : count_q + CNT_ONE;
`ifdef APB_TIMER_ONESHOT_EN
      if (cmp_hit && ctrl_q.oneshot) ctrl_d.en = 1'b0;
`endif

      // Software writes override the tick-driven updates; flag sets still beat W1C.
      if (wr_hit) begin
        case (reg_sel)
          REG_COUNT: begin
            count_d = PWDATA[CNT_WIDTH-1:0];
            pcnt_d  = 4'd0;
          end
          REG_CTRL: begin
            ctrl_d.en      = PWDATA[0];
            ctrl_d.autorst = PWDATA[1];
`ifdef APB_TIMER_ONESHOT_EN
            ctrl_d.oneshot = PWDATA[2];
`else
            ctrl_d.oneshot = 1'b0;
`endif
            ctrl_d.presc   = PWDATA[7:4];
            ctrl_d.ovf_ie  = PWDATA[8];
            ctrl_d.cmp_ie  = PWDATA[9];
            pcnt_d         = 4'd0;
          end
          REG_CMP: begin
            cmp_d   = PWDATA[CNT_WIDTH-1:0];
            count_d = '0;
            pcnt_d  = 4'd0;
          end
          REG_STATUS: status_d = (status_q & ~PWDATA[1:0]) | {cmp_hit, ovf_hit};
        endcase
      end
    end

    always_ff @(posedge HCLK) begin
      // NOTE: state registers use <= so every channel samples pre-edge values.
      if (HRESET) begin
        ctrl_q   <= '0;
        count_q  <= '0;
        cmp_q    <= '0;
        status_q <= '0;
        pcnt_q   <= '0;
      end else begin
        ctrl_q   <= ctrl_d;
        count_q  <= count_d;
        cmp_q    <= cmp_d;
        status_q <= status_d;
        pcnt_q   <= pcnt_d;
      end
    end

    assign rd_count_flat[32*g +: 32]  = 32'(count_q);
    assign rd_cmp_flat[32*g +: 32]    = 32'(cmp_q);
    assign rd_status_flat[32*g +: 32] = {30'd0, status_q};
    assign rd_ctrl_flat[32*g +: 32]   = {22'd0, ctrl_q.cmp_ie, ctrl_q.ovf_ie, ctrl_q.presc,
                                         1'b0, ctrl_q.oneshot, ctrl_q.autorst, ctrl_q.en};
    assign irq_o[g] = (status_q[0] & ctrl_q.ovf_ie) | (status_q[1] & ctrl_q.cmp_ie);
  end

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_idx == 4'(i)) begin
          case (reg_sel)
            REG_COUNT:  PRDATA = rd_count_flat[32*i +: 32];
            REG_CTRL:   PRDATA = rd_ctrl_flat[32*i +: 32];
            REG_CMP:    PRDATA = rd_cmp_flat[32*i +: 32];
            REG_STATUS: PRDATA = rd_status_flat[32*i +: 32];
          endcase
        end
      end
    end
  end

endmodule
